// File: rtl/cpu_pkg.sv
// Shared core definitions: data-memory responder state encoding and default sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word store: synchronous write, asynchronous read, contents survive reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store, stalls the core for a fixed latency,
// then performs the access and returns load data or flags an illegal request.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);

  dmem_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              is_write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              req_one, req_dual;
  logic              illegal, access, mem_we;
  logic              stall_c, err_c;
  logic [DATA_W-1:0] mem_rdata;

  assign req_one  = MemRead ^ MemWrite;
  assign req_dual = MemRead & MemWrite;

  // Legality is judged on the latched address, so it stays stable through DONE.
  assign illegal = (addr_reg[1:0] != 2'b00) || ({1'b0, addr_reg} >= ADDR_LIMIT);
  assign access  = (state_reg == BUSY) && (cnt_reg == '0);
  assign mem_we  = access && is_write_reg && !illegal;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (addr_reg[IDX_W+1:2]),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_one) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
          stall_c    = 1'b1;
        end else if (req_dual) begin
          err_c = 1'b1;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
        else               state_next = DONE;
      end
      DONE: begin
        err_c      = illegal;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even if a request is present.
  assign stall = stall_c & rst_n;
  assign err   = err_c & rst_n;
  assign rdata = rdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req_one) begin
        is_write_reg <= MemWrite;
        addr_reg     <= addr;
        wdata_reg    <= wdata;
      end
      if (access) begin
        if (illegal)            rdata_reg <= '0;
        else if (!is_write_reg) rdata_reg <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 4;

  logic              clk;
  logic              rst_n;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              err;

  dmem_responder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus the last value the load-result register should hold.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One complete load or store; optionally scrambles the request inputs during BUSY.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    bit illegal;
    int cycles;
    int errs;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    illegal = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    cycles = 0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      cycles++;
      if (err) errs++;
      @(posedge clk); #1;
      if (scramble) begin
        addr = $urandom; wdata = $urandom;
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
      end
    end
    if (illegal)  exp_rdata = 32'h0;
    else if (rd)  exp_rdata = mem_m[a[9:2]];
    else          mem_m[a[9:2]] = d;
    check("stall_cycles", cycles, LATENCY + 1);
    check("err_while_stalled", errs, 0);
    check("err_done", {31'b0, err}, {31'b0, illegal});
    check("rdata_done", rdata, exp_rdata);
    $display("txn %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b stall_cycles=%0d",
             rd ? "load " : "store", a, d, rdata, err, cycles);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic dual_request(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    check("dual_err", {31'b0, err}, 32'd1);
    check("dual_stall", {31'b0, stall}, 32'd0);
    $display("txn dual  addr=0x%08h wdata=0x%08h err=%0b stall=%0b", a, d, err, stall);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("dual_after_err", {31'b0, err}, 32'd0);
    check("dual_after_stall", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    exp_rdata = 32'h0;
    #12;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Give every word a known value so any load can be predicted.
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    // Reset during BUSY of a store must discard it.
    access(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    @(posedge clk); #1;
    MemWrite = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midbusy_reset_stall", {31'b0, stall}, 32'd0);
    check("midbusy_reset_err", {31'b0, err}, 32'd0);
    check("midbusy_reset_rdata", rdata, 32'h0);
    MemWrite = 1'b0;
    exp_rdata = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Directed scenarios.
    access(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    dual_request(32'h40, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h80, 32'hA5A5_5A5A, 1'b1);
    access(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);

    // Randomized mix of legal, misaligned, out-of-range and dual requests.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        dual_request($urandom, $urandom);
      end else begin
        if (kind == 1)      a = ($urandom & 32'h3FF) | 32'(($urandom_range(1, 3)));
        else if (kind == 2) a = $urandom_range(32'h400, 32'hFFFF_FFFF) & 32'hFFFF_FFFC;
        else                a = $urandom & 32'h3FC;
        if ($urandom_range(0, 1) == 0) access(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 3) == 0);
        else                           access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3) == 0);
      end
    end

    // Read back a sample of words to confirm no stray writes occurred.
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(i * 64), 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
